// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle MIPS controller: state encoding,
// opcode/funct fields, ALUOp and ALUControl codes, and the control-word struct.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOP_NONE yields ALUControl=000 for states that leave the ALU idle.
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FN   = 2'b10;
  localparam logic [1:0] ALUOP_NONE = 2'b11;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus the R-type funct field to the 3-bit ALUControl code.
module alu_decoder
  import multicycle_controller_pkg::*;
#(
  parameter int FN_W = 6
) (
  input  logic [1:0]      i_alu_op,
  input  logic [FN_W-1:0] i_funct,
  output logic [2:0]      o_alu_ctl
);

  always_comb begin
    o_alu_ctl = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD:  o_alu_ctl = ALU_ADD;
      ALUOP_SUB:  o_alu_ctl = ALU_SUB;
      ALUOP_NONE: o_alu_ctl = 3'b000;
      default: begin
        // Unknown funct codes fall back to add.
        if      (i_funct == FN_W'(FN_ADD)) o_alu_ctl = ALU_ADD;
        else if (i_funct == FN_W'(FN_SUB)) o_alu_ctl = ALU_SUB;
        else if (i_funct == FN_W'(FN_AND)) o_alu_ctl = ALU_AND;
        else if (i_funct == FN_W'(FN_OR))  o_alu_ctl = ALU_OR;
        else if (i_funct == FN_W'(FN_SLT)) o_alu_ctl = ALU_SLT;
        else                               o_alu_ctl = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for a multicycle MIPS datapath (lw/sw/R-type/beq/addi/j).
// DbgState exposes the current state for checkers.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FN_W = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [OP_W-1:0] Op,
  input  logic [FN_W-1:0] Funct,
  input  logic            Zero,
  output logic            PCEn,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            IorD,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSrc,
  output logic [2:0]      ALUControl,
  output logic [3:0]      DbgState
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   w_is_lw, w_is_sw, w_is_r, w_is_beq, w_is_addi, w_is_j;

  assign w_is_lw   = (Op == OP_W'(OP_LW));
  assign w_is_sw   = (Op == OP_W'(OP_SW));
  assign w_is_r    = (Op == OP_W'(OP_R));
  assign w_is_beq  = (Op == OP_W'(OP_BEQ));
  assign w_is_addi = (Op == OP_W'(OP_ADDI));
  assign w_is_j    = (Op == OP_W'(OP_J));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_lw || w_is_sw) w_next = S_MEMADR;
        else if (w_is_r)        w_next = S_EXEC;
        else if (w_is_beq)      w_next = S_BRANCH;
        else if (w_is_addi)     w_next = S_ADDIEX;
        else if (w_is_j)        w_next = S_JUMP;
        else                    w_next = S_FETCH;
      end
      S_MEMADR: w_next = w_is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl        = '0;
    w_ctrl.alu_op = ALUOP_NONE;
    case (r_state)
      S_FETCH: begin
        w_ctrl.alu_src_b = 2'b01;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.ir_write  = 1'b1;
        w_ctrl.pc_en     = 1'b1;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = 2'b11;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'b10;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: w_ctrl.iord = 1'b1;
      S_MEMWB: begin
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALUOP_FN;
      end
      S_ALUWB: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = ALUOP_SUB;
        w_ctrl.pc_src    = 2'b01;
        w_ctrl.pc_en     = Zero;
      end
      S_ADDIWB: w_ctrl.reg_write = 1'b1;
      S_JUMP: begin
        w_ctrl.pc_src = 2'b10;
        w_ctrl.pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder #(.FN_W(FN_W)) u_alu_decoder (
    .i_alu_op  (w_ctrl.alu_op),
    .i_funct   (Funct),
    .o_alu_ctl (ALUControl)
  );

  // Reset forces FETCH asynchronously; write enables are gated so an abort is immediate.
  assign PCEn     = w_ctrl.pc_en     & ~RST;
  assign IRWrite  = w_ctrl.ir_write  & ~RST;
  assign RegWrite = w_ctrl.reg_write & ~RST;
  assign MemWrite = w_ctrl.mem_write & ~RST;
  assign IorD     = w_ctrl.iord;
  assign RegDst   = w_ctrl.reg_dst;
  assign MemtoReg = w_ctrl.mem_to_reg;
  assign ALUSrcA  = w_ctrl.alu_src_a;
  assign ALUSrcB  = w_ctrl.alu_src_b;
  assign PCSrc    = w_ctrl.pc_src;
  assign DbgState = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control words
// are queued per instruction and compared every cycle on the falling edge.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  localparam int VW = 19;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] Op = '0;
  logic [5:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       PCEn, IRWrite, RegWrite, MemWrite, IorD, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] DbgState;

  logic [VW-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  multicycle_controller #(.OP_W(6), .FN_W(6)) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCEn(PCEn), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .DbgState(DbgState)
  );

  always #5 CLK = ~CLK;

  // Word layout: state, {PCEn IRWrite RegWrite MemWrite IorD RegDst MemtoReg ALUSrcA}, ALUSrcB, PCSrc, ALUControl
  function automatic logic [VW-1:0] mk(input state_t st, input logic [7:0] en,
                                       input logic [1:0] srcb, input logic [1:0] pcsrc,
                                       input logic [2:0] alu);
    return {4'(st), en, srcb, pcsrc, alu};
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [VW-1:0] observed();
    return {DbgState, PCEn, IRWrite, RegWrite, MemWrite, IorD, RegDst, MemtoReg,
            ALUSrcA, ALUSrcB, PCSrc, ALUControl};
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Call while the DUT is in FETCH; returns in the next FETCH (or in reset if abort_last).
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input bit abort_last);
    int n;
    Op = op; Funct = fn; Zero = z;
    exp_q.push_back(mk(S_FETCH,  8'b1100_0000, 2'b01, 2'b00, 3'b010));
    exp_q.push_back(mk(S_DECODE, 8'b0000_0000, 2'b11, 2'b00, 3'b010));
    case (op)
      6'b100011: begin
        exp_q.push_back(mk(S_MEMADR, 8'b0000_0001, 2'b10, 2'b00, 3'b010));
        exp_q.push_back(mk(S_MEMRD,  8'b0000_1000, 2'b00, 2'b00, 3'b000));
        exp_q.push_back(mk(S_MEMWB,  8'b0010_0010, 2'b00, 2'b00, 3'b000));
      end
      6'b101011: begin
        exp_q.push_back(mk(S_MEMADR, 8'b0000_0001, 2'b10, 2'b00, 3'b010));
        exp_q.push_back(mk(S_MEMWR,  8'b0001_1000, 2'b00, 2'b00, 3'b000));
      end
      6'b000000: begin
        exp_q.push_back(mk(S_EXEC,  8'b0000_0001, 2'b00, 2'b00, ref_alu(fn)));
        exp_q.push_back(mk(S_ALUWB, 8'b0010_0100, 2'b00, 2'b00, 3'b000));
      end
      6'b000100: exp_q.push_back(mk(S_BRANCH, {z, 7'b000_0001}, 2'b00, 2'b01, 3'b110));
      6'b001000: begin
        exp_q.push_back(mk(S_ADDIEX, 8'b0000_0001, 2'b10, 2'b00, 3'b010));
        exp_q.push_back(mk(S_ADDIWB, 8'b0010_0000, 2'b00, 2'b00, 3'b000));
      end
      6'b000010: exp_q.push_back(mk(S_JUMP, 8'b1000_0000, 2'b00, 2'b10, 3'b000));
      default: ;
    endcase
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge CLK);
      #1;
      check($sformatf("%s_c%0d", name, i + 1), observed(), exp_q.pop_front());
    end
    if (abort_last) begin
      RST = 1'b1;
      #1;
      check({name, "_abort"}, observed(), mk(S_FETCH, 8'b0000_0000, 2'b01, 2'b00, 3'b010));
      @(negedge CLK);
      #1;
      check({name, "_abort_hold"}, observed(), mk(S_FETCH, 8'b0000_0000, 2'b01, 2'b00, 3'b010));
      RST = 1'b0;
    end else begin
      @(negedge CLK);
    end
  endtask

  logic [5:0] rand_ops[6];
  logic [5:0] rand_fns[6];

  initial begin
    rand_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    rand_fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};

    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      check($sformatf("reset_c%0d", i + 1), observed(),
            mk(S_FETCH, 8'b0000_0000, 2'b01, 2'b00, 3'b010));
    end
    RST = 1'b0;
    #1;
    check("reset_release", observed(), mk(S_FETCH, 8'b1100_0000, 2'b01, 2'b00, 3'b010));

    run_instr("lw",       6'b100011, 6'b000000, 1'b0, 1'b0);
    run_instr("sw",       6'b101011, 6'b000000, 1'b0, 1'b0);
    run_instr("r_add",    6'b000000, 6'b100000, 1'b0, 1'b0);
    run_instr("r_sub",    6'b000000, 6'b100010, 1'b0, 1'b0);
    run_instr("r_and",    6'b000000, 6'b100100, 1'b0, 1'b0);
    run_instr("r_or",     6'b000000, 6'b100101, 1'b0, 1'b0);
    run_instr("r_slt",    6'b000000, 6'b101010, 1'b0, 1'b0);
    run_instr("r_badfn",  6'b000000, 6'b000111, 1'b0, 1'b0);
    run_instr("beq_z1",   6'b000100, 6'b000000, 1'b1, 1'b0);
    run_instr("beq_z0",   6'b000100, 6'b000000, 1'b0, 1'b0);
    run_instr("addi",     6'b001000, 6'b000000, 1'b0, 1'b0);
    run_instr("j",        6'b000010, 6'b000000, 1'b0, 1'b0);
    run_instr("ill_3f",   6'b111111, 6'b000000, 1'b0, 1'b0);
    run_instr("ill_01",   6'b000001, 6'b100010, 1'b1, 1'b0);
    run_instr("sw_abort", 6'b101011, 6'b000000, 1'b0, 1'b1);
    #1;
    check("after_abort", observed(), mk(S_FETCH, 8'b1100_0000, 2'b01, 2'b00, 3'b010));

    for (int k = 0; k < 8; k++) begin
      run_instr($sformatf("rnd%0d", k), rand_ops[$urandom_range(0, 5)],
                rand_fns[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
